// File: rtl/instruction_utils_pkg.sv
// Shared RV32I instruction encoding and LSU state type.
// Helpers classify memory ops and detect misaligned accesses.
package instruction_utils;

    typedef enum logic [5:0] {
        InstrLui, InstrAuipc, InstrJal, InstrJalr,
        InstrBeq, InstrBne, InstrBlt, InstrBge, InstrBltu, InstrBgeu,
        InstrLb, InstrLh, InstrLw, InstrLbu, InstrLhu,
        InstrSb, InstrSh, InstrSw,
        InstrAddi, InstrSlti, InstrSltiu, InstrXori, InstrOri, InstrAndi,
        InstrSlli, InstrSrli, InstrSrai,
        InstrAdd, InstrSub, InstrSll, InstrSlt, InstrSltu, InstrXor,
        InstrSrl, InstrSra, InstrOr, InstrAnd,
        InstrFence, InstrEcall, InstrEbreak
    } rv32i_instr_e;

    typedef enum logic [1:0] {
        LsuIdle,
        LsuMem,
        LsuResp
    } lsu_state_e;

    function automatic logic is_load(input rv32i_instr_e i);
        return i inside {InstrLb, InstrLh, InstrLw, InstrLbu, InstrLhu};
    endfunction

    function automatic logic is_store(input rv32i_instr_e i);
        return i inside {InstrSb, InstrSh, InstrSw};
    endfunction

    function automatic logic is_misaligned(input rv32i_instr_e i, input logic [1:0] a);
        logic mis;
        case (i)
            InstrLh, InstrLhu, InstrSh: mis = a[0];
            InstrLw, InstrSw:           mis = (a != 2'b00);
            default:                    mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Load lane selection and sign/zero extension of a memory read word.
// Produces zero for anything that is not a load.
module lsu_align
    import instruction_utils::*;
(
    input  rv32i_instr_e instr,
    input  logic [1:0]   addr_lo,
    input  logic [31:0]  rdata,
    output logic [31:0]  data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        unique case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (instr)
            InstrLb:  data = {{24{byte_sel[7]}}, byte_sel};
            InstrLbu: data = {24'd0, byte_sel};
            InstrLh:  data = {{16{half_sel[15]}}, half_sel};
            InstrLhu: data = {16'd0, half_sel};
            InstrLw:  data = rdata;
            default:  data = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit between execute stage and data memory.
// Misaligned and non-memory ops bypass the memory and complete with done.
module lsu
    import instruction_utils::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  rv32i_instr_e instr,
    input  logic [31:0]  addr,
    input  logic [31:0]  store_data,
    output logic         done,
    output logic [31:0]  load_data,
    output logic         misaligned,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    output logic [3:0]   mem_wstrb,
    input  logic         mem_ready,
    input  logic [31:0]  mem_rdata
);

    lsu_state_e   state_q;
    rv32i_instr_e instr_q;
    logic [31:0]  addr_q;
    logic [31:0]  store_data_q;
    logic         mis_pend_q;
    logic         done_q;
    logic         misaligned_q;
    logic [31:0]  load_data_q;
    logic [31:0]  align_data;

    lsu_align u_align (
        .instr   (instr_q),
        .addr_lo (addr_q[1:0]),
        .rdata   (mem_rdata),
        .data    (align_data)
    );

    // Bypassed ops spend two cycles in RESP so they never complete faster
    // than a zero-wait memory access: first cycle arms done_q, second pulses it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= LsuIdle;
            instr_q      <= InstrLui;
            addr_q       <= 32'd0;
            store_data_q <= 32'd0;
            mis_pend_q   <= 1'b0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            load_data_q  <= 32'd0;
        end else begin
            unique case (state_q)
                LsuIdle: begin
                    if (req_valid) begin
                        instr_q      <= instr;
                        addr_q       <= addr;
                        store_data_q <= store_data;
                        mis_pend_q   <= is_misaligned(instr, addr[1:0]);
                        load_data_q  <= 32'd0;
                        if ((is_load(instr) || is_store(instr)) &&
                            !is_misaligned(instr, addr[1:0])) begin
                            state_q <= LsuMem;
                        end else begin
                            state_q <= LsuResp;
                        end
                    end
                end
                LsuMem: begin
                    if (mem_ready) begin
                        state_q     <= LsuResp;
                        done_q      <= 1'b1;
                        load_data_q <= align_data;
                    end
                end
                LsuResp: begin
                    if (done_q) begin
                        state_q      <= LsuIdle;
                        done_q       <= 1'b0;
                        misaligned_q <= 1'b0;
                        load_data_q  <= 32'd0;
                        mis_pend_q   <= 1'b0;
                    end else begin
                        done_q       <= 1'b1;
                        misaligned_q <= mis_pend_q;
                    end
                end
                default: state_q <= LsuIdle;
            endcase
        end
    end

    assign req_ready  = (state_q == LsuIdle);
    assign done       = done_q;
    assign misaligned = misaligned_q;
    assign load_data  = load_data_q;
    assign mem_req    = (state_q == LsuMem);
    assign mem_we     = mem_req && is_store(instr_q);
    assign mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;

    always_comb begin
        mem_wstrb = 4'b0000;
        mem_wdata = 32'd0;
        if (mem_req) begin
            case (instr_q)
                InstrSb: begin
                    mem_wstrb = 4'b0001 << addr_q[1:0];
                    mem_wdata = {4{store_data_q[7:0]}};
                end
                InstrSh: begin
                    mem_wstrb = 4'b0011 << addr_q[1:0];
                    mem_wdata = {2{store_data_q[15:0]}};
                end
                InstrSw: begin
                    mem_wstrb = 4'b1111;
                    mem_wdata = store_data_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed scenarios followed by randomized ops checked
// against an arithmetic reference model of the load/store rules.
module tb_lsu;
    import instruction_utils::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    rv32i_instr_e instr;
    logic [31:0]  addr;
    logic [31:0]  store_data;
    logic         done;
    logic [31:0]  load_data;
    logic         misaligned;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_wstrb;
    logic         mem_ready;
    logic [31:0]  mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    lsu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .instr      (instr),
        .addr       (addr),
        .store_data (store_data),
        .done       (done),
        .load_data  (load_data),
        .misaligned (misaligned),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic rv32i_instr_e rand_instr();
        return rv32i_instr_e'(6'($urandom_range(0, 39)));
    endfunction

    // Reference: access size in bytes, lane = addr mod 4, extension by masking.
    function automatic void model(input rv32i_instr_e op, input logic [31:0] a,
                                  input logic [31:0] sd, input logic [31:0] rd,
                                  output logic go, output logic we, output logic mis,
                                  output logic [3:0] strb, output logic [31:0] wd,
                                  output logic [31:0] ld);
        int size;
        bit ld_op, st_op, sgn;
        logic [31:0] mask, v;
        size = 0; ld_op = 0; st_op = 0; sgn = 0;
        case (op)
            InstrLb:  begin size = 1; ld_op = 1; sgn = 1; end
            InstrLbu: begin size = 1; ld_op = 1; end
            InstrLh:  begin size = 2; ld_op = 1; sgn = 1; end
            InstrLhu: begin size = 2; ld_op = 1; end
            InstrLw:  begin size = 4; ld_op = 1; end
            InstrSb:  begin size = 1; st_op = 1; end
            InstrSh:  begin size = 2; st_op = 1; end
            InstrSw:  begin size = 4; st_op = 1; end
            default:  size = 0;
        endcase
        mis  = (size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00);
        go   = (ld_op || st_op) && !mis;
        we   = go && st_op;
        strb = 4'b0000;
        wd   = 32'd0;
        ld   = 32'd0;
        if (go && st_op) begin
            strb = 4'(((1 << size) - 1) << a[1:0]);
            if (size == 1)      wd = {24'd0, sd[7:0]} * 32'h0101_0101;
            else if (size == 2) wd = {16'd0, sd[15:0]} * 32'h0001_0001;
            else                wd = sd;
        end
        if (go && ld_op) begin
            mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
            v = (rd >> (8 * a[1:0])) & mask;
            if (sgn && v[8 * size - 1]) v = v | ~mask;
            ld = v;
        end
    endfunction

    task automatic run_op(input rv32i_instr_e op, input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rd, input int wait_cycles, input bit noise);
        logic go, we, mis;
        logic [3:0] strb;
        logic [31:0] wd, ld;
        model(op, a, sd, rd, go, we, mis, strb, wd, ld);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; instr = op; addr = a; store_data = sd; mem_ready = 1'b0;
        step();
        req_valid = 1'b0;
        if (go) begin
            for (int i = 0; i <= wait_cycles; i++) begin
                if (noise) begin
                    req_valid = 1'b1; instr = rand_instr(); addr = $urandom; store_data = $urandom;
                end
                mem_ready = (i == wait_cycles);
                mem_rdata = (i == wait_cycles) ? rd : $urandom;
                check("mem_req", {31'd0, mem_req}, 32'd1);
                check("mem_we", {31'd0, mem_we}, {31'd0, we});
                check("mem_addr", mem_addr, {a[31:2], 2'b00});
                check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, strb});
                check("mem_wdata", mem_wdata, wd);
                check("req_ready_busy", {31'd0, req_ready}, 32'd0);
                check("done_early", {31'd0, done}, 32'd0);
                step();
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (noise) begin
                    mem_ready = 1'($urandom); mem_rdata = $urandom;
                    req_valid = 1'b1; instr = rand_instr(); addr = $urandom;
                end
                check("bypass_mem_req", {31'd0, mem_req}, 32'd0);
                check("bypass_done", {31'd0, done}, i == 1 ? 32'd1 : 32'd0);
                check("bypass_ready", {31'd0, req_ready}, 32'd0);
                if (i == 0) step();
            end
        end
        mem_ready = 1'b0; req_valid = 1'b0;
        check("done", {31'd0, done}, 32'd1);
        check("misaligned", {31'd0, misaligned}, {31'd0, mis});
        check("load_data", load_data, ld);
        check("done_mem_req", {31'd0, mem_req}, 32'd0);
        check("done_ready", {31'd0, req_ready}, 32'd0);
        step();
        check("after_done", {31'd0, done}, 32'd0);
        check("after_mis", {31'd0, misaligned}, 32'd0);
        check("after_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        rv32i_instr_e op;
        logic [31:0] a;
        rst_n = 1'b0; req_valid = 1'b0; mem_ready = 1'b0; instr = InstrLw;
        addr = 32'd0; store_data = 32'd0; mem_rdata = 32'd0;
        step();
        step();
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_mis", {31'd0, misaligned}, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        rst_n = 1'b1;
        step();

        run_op(InstrLw, 32'h100, 32'd0, 32'hDEAD_BEEF, 3, 1'b0);
        check("lw_value", load_data, 32'd0);
        run_op(InstrLb, 32'h103, 32'd0, 32'h80FF_FF00, 0, 1'b0);
        run_op(InstrLbu, 32'h103, 32'd0, 32'h80FF_FF00, 0, 1'b0);
        run_op(InstrSh, 32'h202, 32'h1234_ABCD, 32'hFFFF_FFFF, 1, 1'b0);
        run_op(InstrLw, 32'h101, 32'd0, 32'd0, 0, 1'b0);

        // Back-pressure, then reset while the store is stalled.
        req_valid = 1'b1; instr = InstrSw; addr = 32'h344; store_data = 32'hCAFE_F00D;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_mem_req", {31'd0, mem_req}, 32'd1);
            check("bp_mem_addr", mem_addr, 32'h344);
            check("bp_mem_wdata", mem_wdata, 32'hCAFE_F00D);
            check("bp_mem_wstrb", {28'd0, mem_wstrb}, 32'hF);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
            step();
        end
        rst_n = 1'b0;
        step();
        check("rst_mem_req_drop", {31'd0, mem_req}, 32'd0);
        check("rst_no_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        step();
        check("rel_req_ready", {31'd0, req_ready}, 32'd1);
        check("rel_no_done", {31'd0, done}, 32'd0);

        // Back-to-back: request in the done cycle must wait for IDLE.
        req_valid = 1'b1; instr = InstrLh; addr = 32'h11;
        step();
        req_valid = 1'b0;
        step();
        check("b2b_done", {31'd0, done}, 32'd1);
        check("b2b_mis", {31'd0, misaligned}, 32'd1);
        req_valid = 1'b1; instr = InstrLw; addr = 32'h40;
        check("b2b_not_ready", {31'd0, req_ready}, 32'd0);
        step();
        check("b2b_idle_ready", {31'd0, req_ready}, 32'd1);
        check("b2b_not_taken", {31'd0, mem_req}, 32'd0);
        step();
        req_valid = 1'b0;
        check("b2b_taken", {31'd0, mem_req}, 32'd1);
        check("b2b_addr", mem_addr, 32'h40);
        mem_ready = 1'b1; mem_rdata = 32'h1122_3344;
        step();
        mem_ready = 1'b0;
        check("b2b_load", load_data, 32'h1122_3344);
        step();

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) < 8)
                op = rv32i_instr_e'(6'($urandom_range(int'(InstrLb), int'(InstrSw))));
            else
                op = rand_instr();
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            run_op(op, a, $urandom, $urandom, $urandom_range(0, 3), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
